// File: rtl/fir_xifu_scoreboard_if.sv
// Scoreboard handshake bundle: decode issue channel, X-IF commit channel,
// writeback channel, flush request and scoreboard status outputs.
// master = pipeline side (drives requests), slave = scoreboard side.
interface fir_xifu_scoreboard_if #(
    parameter int Depth        = 4,
    parameter int IdWidth      = 4,
    parameter int RegAddrWidth = 3,
    parameter int NumRs        = 2
);
    localparam int CntWidth = $clog2(Depth + 1);

    logic                          clear;
    // issue channel (decode)
    logic                          issue_valid;
    logic                          issue_ready;
    logic [IdWidth-1:0]            issue_id;
    logic [RegAddrWidth-1:0]       issue_rd;
    logic                          issue_rd_we;
    logic [NumRs*RegAddrWidth-1:0] issue_rs;
    logic [NumRs-1:0]              issue_rs_used;
    // commit channel (X-IF)
    logic                          commit_valid;
    logic [IdWidth-1:0]            commit_id;
    logic                          commit_kill;
    // writeback channel
    logic                          wb_valid;
    logic [IdWidth-1:0]            wb_id;
    // status
    logic [CntWidth-1:0]           inflight;
    logic                          full;
    logic                          empty;
    logic                          hazard;
    logic                          err;

    modport master (
        output clear, issue_valid, issue_id, issue_rd, issue_rd_we, issue_rs, issue_rs_used,
               commit_valid, commit_id, commit_kill, wb_valid, wb_id,
        input  issue_ready, inflight, full, empty, hazard, err
    );

    modport slave (
        input  clear, issue_valid, issue_id, issue_rd, issue_rd_we, issue_rs, issue_rs_used,
               commit_valid, commit_id, commit_kill, wb_valid, wb_id,
        output issue_ready, inflight, full, empty, hazard, err
    );
endinterface

// File: rtl/fir_xifu_scoreboard.sv
// In-flight tracker for FIR coprocessor instructions keyed by X-IF id.
// Latency: issue -> entry visible 1 cycle; commit/wb free -> hazard release 1 cycle.
// Backpressure: issue_ready drops on RAW/WAW hazard, duplicate id, full table, reset or clear.
// Ports: clk_i, rst_i (sync active-high), sb (slave modport: issue/commit/wb/clear in, status out).
module fir_xifu_scoreboard #(
    parameter int Depth        = 4,
    parameter int IdWidth      = 4,
    parameter int RegAddrWidth = 3,
    parameter int NumRs        = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    fir_xifu_scoreboard_if.slave sb
);
    localparam int CntWidth = $clog2(Depth + 1);
    localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Depth-1:0]        valid_q, valid_n;
    logic [Depth-1:0]        committed_q, committed_n;
    logic [Depth-1:0]        rd_we_q;
    logic [IdWidth-1:0]      id_q [Depth];
    logic [RegAddrWidth-1:0] rd_q [Depth];
    logic                    err_q, err_n;
    logic [CntWidth-1:0]     inflight_q, inflight_n;

    logic                    flush;
    logic                    hazard;
    logic                    full;
    logic                    ready;
    logic                    accept;
    logic                    wb_hit;
    logic [IdxWidth-1:0]     alloc_idx;

    assign flush = rst_i | sb.clear;
    assign full  = (inflight_q == CntWidth'(Depth));
    assign ready = ~flush & ~full & ~hazard;
    assign accept = sb.issue_valid & ready;

    // Hazard check looks only at the registered table: frees happening this
    // cycle are deliberately not bypassed.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (valid_q[i]) begin
                if (id_q[i] == sb.issue_id) hazard = 1'b1;
                if (rd_we_q[i]) begin
                    if (sb.issue_rd_we && (rd_q[i] == sb.issue_rd)) hazard = 1'b1;
                    for (int k = 0; k < NumRs; k++) begin
                        if (sb.issue_rs_used[k] &&
                            (rd_q[i] == sb.issue_rs[k*RegAddrWidth +: RegAddrWidth]))
                            hazard = 1'b1;
                    end
                end
            end
        end
        hazard = hazard & sb.issue_valid;
    end

    // Lowest free slot in the registered table, so a slot freed this cycle
    // is never reused in the same cycle.
    always_comb begin
        alloc_idx = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (!valid_q[i]) alloc_idx = IdxWidth'(i);
        end
    end

    // Next table state: commit first, then writeback sees the post-commit
    // view (so commit+wb of one id in one cycle retires cleanly), then issue.
    always_comb begin
        valid_n     = valid_q;
        committed_n = committed_q;
        err_n       = err_q;
        wb_hit      = 1'b0;
        inflight_n  = '0;

        if (sb.commit_valid) begin
            for (int i = 0; i < Depth; i++) begin
                if (valid_q[i] && (id_q[i] == sb.commit_id)) begin
                    if (sb.commit_kill) valid_n[i] = 1'b0;
                    else                committed_n[i] = 1'b1;
                end
            end
        end

        if (sb.wb_valid) begin
            for (int i = 0; i < Depth; i++) begin
                if (valid_n[i] && committed_n[i] && (id_q[i] == sb.wb_id)) begin
                    valid_n[i] = 1'b0;
                    wb_hit     = 1'b1;
                end
            end
            if (!wb_hit) err_n = 1'b1;
        end

        if (accept) begin
            valid_n[alloc_idx]     = 1'b1;
            committed_n[alloc_idx] = 1'b0;
        end

        for (int i = 0; i < Depth; i++) begin
            inflight_n = inflight_n + CntWidth'(valid_n[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (flush) begin
            valid_q     <= '0;
            committed_q <= '0;
            err_q       <= 1'b0;
            inflight_q  <= '0;
        end else begin
            valid_q     <= valid_n;
            committed_q <= committed_n;
            err_q       <= err_n;
            inflight_q  <= inflight_n;
        end
    end

    // Payload fields are only meaningful while valid, so they carry no reset.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_q[alloc_idx]    <= sb.issue_id;
            rd_q[alloc_idx]    <= sb.issue_rd;
            rd_we_q[alloc_idx] <= sb.issue_rd_we;
        end
    end

    assign sb.issue_ready = ready;
    assign sb.hazard      = hazard;
    assign sb.full        = full;
    assign sb.empty       = (inflight_q == '0);
    assign sb.inflight    = inflight_q;
    assign sb.err         = err_q;
endmodule
